// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU run/step clock controller: state encoding
// and debounce lengths for hardware builds and for simulation.
package cpu_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HALT      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2
  } state_t;

  // 20 ms at 50 MHz for real switches; a short window keeps simulations quick
  localparam int DEBOUNCE_CYCLES_HW  = 1_000_000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  // Counter width able to hold DEBOUNCE_CYCLES-1, never narrower than one bit
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_debounce_sync.sv
// Two-flop synchroniser followed by a debouncer: the stable level follows the
// input only after it has differed for DEBOUNCE_CYCLES consecutive samples.
module debounce_sync
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample matching the current level restarts the window
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step controller: turns the divided clock into a one-cycle CPU enable,
// gated by debounced run switch and step button, and counts issued enables.
module cpu_clk_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
  parameter int CNT_W           = 32
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             div_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             running,
  output logic             step_pending
);

  state_t state;
  state_t state_nxt;
  logic   div_d;
  logic   div_rise;
  logic   run_stable;
  logic   step_stable;
  logic   step_stable_d;
  logic   step_press;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .raw     (run_sw),
    .stable  (run_stable)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .raw     (step_btn),
    .stable  (step_stable)
  );

  // div_clk is already a sys_clk-domain register, so a single delay suffices
  assign div_rise   = div_clk & ~div_d;
  assign step_press = step_stable & ~step_stable_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_d         <= 1'b0;
      step_stable_d <= 1'b0;
      state         <= HALT;
    end else begin
      div_d         <= div_clk;
      step_stable_d <= step_stable;
      state         <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HALT: begin
        if (run_stable) begin
          state_nxt = RUN;
        end else if (step_press) begin
          state_nxt = STEP_WAIT;
        end
      end
      RUN: begin
        if (!run_stable) begin
          state_nxt = HALT;
        end
      end
      STEP_WAIT: begin
        if (div_rise) begin
          state_nxt = run_stable ? RUN : HALT;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // A rise seen in the cycle RUN is left still produces its pulse
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_en    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cpu_en <= div_rise & ((state == RUN) | (state == STEP_WAIT));
      if (cpu_en) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

  assign running      = (state == RUN);
  assign step_pending = (state == STEP_WAIT);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cpu_clk_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int D  = DEBOUNCE_CYCLES_SIM;
  localparam int CW = 4;

  logic          sys_clk  = 1'b0;
  logic          rst_n    = 1'b1;
  logic          div_clk  = 1'b0;
  logic          run_sw   = 1'b0;
  logic          step_btn = 1'b0;
  logic          cpu_en;
  logic [CW-1:0] cycle_cnt;
  logic          running;
  logic          step_pending;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit div_hold = 1'b0;
  int div_ph   = 0;

  cpu_clk_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .div_clk      (div_clk),
    .run_sw       (run_sw),
    .step_btn     (step_btn),
    .cpu_en       (cpu_en),
    .cycle_cnt    (cycle_cnt),
    .running      (running),
    .step_pending (step_pending)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // div_clk toggles every 5 cycles; div_hold parks it low
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!(div_hold && !div_clk)) begin
        div_ph++;
        if (div_ph == 5) begin
          div_ph  = 0;
          div_clk = ~div_clk;
        end
      end
    end
  end

  // Behavioural model: an input level is accepted once its synchronised copy
  // has shown the opposite of the accepted level for D samples in a row.
  typedef struct packed {
    logic          div_d;
    logic          r1;
    logic          r2;
    logic [D-1:0]  rwin;
    logic          rlvl;
    logic          s1;
    logic          s2;
    logic [D-1:0]  swin;
    logic          slvl;
    logic          sprev;
    logic [1:0]    mode;   // 0 halted, 1 free-running, 2 waiting for a step
    logic          en;
    logic [CW-1:0] cnt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(input mdl_t c, input logic dv,
                                    input logic rs, input logic sb);
    mdl_t n;
    logic rise;
    logic press;
    n     = c;
    rise  = dv & ~c.div_d;
    press = c.slvl & ~c.sprev;
    n.div_d = dv;
    n.r1 = rs;
    n.r2 = c.r1;
    n.rwin = {c.rwin[D-2:0], c.r2};
    if (n.rwin == {D{~c.rlvl}}) n.rlvl = ~c.rlvl;
    n.s1 = sb;
    n.s2 = c.s1;
    n.swin = {c.swin[D-2:0], c.s2};
    if (n.swin == {D{~c.slvl}}) n.slvl = ~c.slvl;
    n.sprev = c.slvl;
    n.en  = rise && (c.mode != 2'd0);
    n.cnt = c.cnt + CW'(c.en);
    case (c.mode)
      2'd0: begin
        if (c.rlvl) n.mode = 2'd1;
        else if (press) n.mode = 2'd2;
      end
      2'd1: if (!c.rlvl) n.mode = 2'd0;
      2'd2: if (rise) n.mode = c.rlvl ? 2'd1 : 2'd0;
      default: n.mode = 2'd0;
    endcase
    return n;
  endfunction

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= mdl_next(m, div_clk, run_sw, step_btn);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  always @(negedge sys_clk) begin
    chk("model_cpu_en", 32'(cpu_en), 32'(m.en));
    chk("model_cycle_cnt", 32'(cycle_cnt), 32'(m.cnt));
    chk("model_running", 32'(running), 32'(m.mode == 2'd1));
    chk("model_step_pending", 32'(step_pending), 32'(m.mode == 2'd2));
  end

  task automatic wait_running(input string nm, input logic lvl, input int lo, input int hi);
    int n = 0;
    while (running !== lvl && n < hi + 5) begin
      @(negedge sys_clk);
      n++;
    end
    chk_range(nm, n, lo, hi);
  endtask

  task automatic collect_pulses(input string nm, input int want, input bit check_gap);
    int k = 0;
    int guard = 0;
    int t_prev = 0;
    while (k < want && guard < want * 10 + 40) begin
      @(negedge sys_clk);
      guard++;
      if (cpu_en) begin
        if (check_gap && k > 0) chk("pulse_gap", 32'(cyc - t_prev), 32'd10);
        t_prev = cyc;
        k++;
      end
    end
    chk(nm, 32'(k), 32'(want));
  endtask

  initial begin
    int pulses;
    int sp;

    // Asynchronous reset with no clock edge yet
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_step_pending", 32'(step_pending), 32'd0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;

    // Idle
    pulses = 0;
    repeat (200) begin
      @(negedge sys_clk);
      if (cpu_en) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("idle_running", 32'(running), 32'd0);

    // Free run
    run_sw = 1'b1;
    wait_running("run_rise_delay", 1'b1, 6, 7);
    collect_pulses("run_pulses", 5, 1'b1);
    @(negedge sys_clk);
    chk("run_cnt_after5", 32'(cycle_cnt), 32'd5);

    // Step presses during RUN are ignored
    sp = 0;
    step_btn = 1'b1;
    repeat (10) begin @(negedge sys_clk); if (step_pending) sp++; end
    step_btn = 1'b0;
    repeat (10) begin @(negedge sys_clk); if (step_pending) sp++; end
    chk("run_step_ignored", 32'(sp), 32'd0);

    // Stop
    run_sw = 1'b0;
    wait_running("run_fall_delay", 1'b0, 6, 7);
    pulses = 0;
    repeat (40) begin @(negedge sys_clk); if (cpu_en) pulses++; end
    chk("stop_pulses", 32'(pulses), 32'd0);

    // Bounce rejection
    pulses = 0;
    sp = 0;
    for (int i = 0; i < 15; i++) begin
      step_btn = ~step_btn;
      repeat (2) begin
        @(negedge sys_clk);
        if (cpu_en) pulses++;
        if (step_pending) sp++;
      end
    end
    step_btn = 1'b0;
    repeat (30) begin
      @(negedge sys_clk);
      if (cpu_en) pulses++;
      if (step_pending) sp++;
    end
    chk("bounce_step_pending", 32'(sp), 32'd0);
    chk("bounce_pulses", 32'(pulses), 32'd0);

    // Single step with div_clk parked so STEP_WAIT lasts across a second press
    div_hold = 1'b1;
    repeat (20) @(negedge sys_clk);
    pulses = 0;
    step_btn = 1'b1;
    repeat (10) @(negedge sys_clk);
    step_btn = 1'b0;
    chk("step_pending_on", 32'(step_pending), 32'd1);
    repeat (10) begin @(negedge sys_clk); if (cpu_en) pulses++; end
    step_btn = 1'b1;
    repeat (10) begin @(negedge sys_clk); if (cpu_en) pulses++; end
    step_btn = 1'b0;
    repeat (10) begin @(negedge sys_clk); if (cpu_en) pulses++; end
    chk("step_parked_pulses", 32'(pulses), 32'd0);
    chk("step_still_pending", 32'(step_pending), 32'd1);
    div_hold = 1'b0;
    repeat (40) begin @(negedge sys_clk); if (cpu_en) pulses++; end
    chk("step_one_pulse", 32'(pulses), 32'd1);
    chk("step_back_halt_sp", 32'(step_pending), 32'd0);
    chk("step_back_halt_run", 32'(running), 32'd0);

    // Asynchronous reset in the middle of RUN
    run_sw = 1'b1;
    wait_running("run_rise2_delay", 1'b1, 6, 7);
    repeat (23) @(negedge sys_clk);
    @(posedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cpu_en", 32'(cpu_en), 32'd0);
    chk("arst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    wait_running("arst_rerun_delay", 1'b1, 6, 7);

    // Counter wrap with a 4-bit count
    collect_pulses("wrap_pulses", 17, 1'b0);
    @(negedge sys_clk);
    chk("wrap_cycle_cnt", 32'(cycle_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
